atax_csr_ctrl: RTL and testbench

//  Avalon-MM slave control/status block placed directly upstream of the ATAX accelerator top.
//  The HPS writes a CSR to launch a run. The block drives a one-cycle start pulse and waits for
//  the finish pulse, then latches done and optionally raises an IRQ.
//  It also counts run cycles, enforces an optional timeout, and can pulse a kernel reset to abort.

---
 rtl/atax_csr_pkg.sv | 25 ++
 rtl/atax_csr_if.sv | 23 ++
 rtl/atax_run_counter.sv | 32 +++
 rtl/atax_csr_ctrl.sv | 139 +++++++++++++
 tb/tb_atax_csr_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/atax_csr_pkg.sv
// Shared definitions for the ATAX CSR control block: CSR word offsets,
// CTRL/STATUS bit positions and the run FSM state encoding.
package atax_csr_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CYCLES  = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TMO     = 2;
  localparam int ST_ABORTED = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_KRST = 2'd2
  } state_t;

endpackage

// File: rtl/atax_csr_if.sv
// Avalon-MM CSR slave bus (no waitrequest, fixed read latency 1).
//   avs_csr_address   : word address (CTRL, STATUS, CYCLES, TIMEOUT)
//   avs_csr_read      : read strobe
//   avs_csr_write     : write strobe
//   avs_csr_writedata : write data
//   avs_csr_readdata  : read data, valid the cycle after avs_csr_read
interface atax_csr_if #(parameter int DATA_W = 32);
  logic [1:0]        avs_csr_address;
  logic              avs_csr_read;
  logic              avs_csr_write;
  logic [DATA_W-1:0] avs_csr_writedata;
  logic [DATA_W-1:0] avs_csr_readdata;

  modport master (
    output avs_csr_address, avs_csr_read, avs_csr_write, avs_csr_writedata,
    input  avs_csr_readdata
  );

  modport slave (
    input  avs_csr_address, avs_csr_read, avs_csr_write, avs_csr_writedata,
    output avs_csr_readdata
  );
endinterface

// File: rtl/atax_run_counter.sv
// Saturating run-cycle counter with timeout compare.
//   clk, reset : clock, async active-high reset
//   load       : load the count with 1 (first run cycle)
//   en         : increment by one, sticking at all-ones
//   limit      : timeout value; 0 disables the compare
//   count      : current count (holds whenever en and load are low)
//   hit        : count equals a non-zero limit
module atax_run_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         hit
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(1);
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign hit = (limit != '0) && (count == limit);

endmodule

// File: rtl/atax_csr_ctrl.sv
// Control/status block in front of the ATAX accelerator. The host launches a
// run through CTRL, the block pulses start, counts cycles until finish, and
// latches DONE / TMO / ABORTED with an optional level IRQ. A timeout or abort
// drives a fixed-length kernel reset before returning to idle.
//   clk, reset        : clock, async active-high reset
//   csr               : Avalon-MM CSR slave
//   ins_irq_irq       : level interrupt, IRQ_EN & any sticky flag (registered)
//   coe_start_export  : one-cycle start pulse, first RUN cycle
//   coe_finish_export : finish pulse from the accelerator
//   coe_kreset_export : kernel reset, high for KRESET_CYCLES cycles
//
// state  | meaning
// IDLE   | waiting for START
// RUN    | accelerator running, cycle counter advancing
// KRST   | kernel reset after timeout or abort
module atax_csr_ctrl
  import atax_csr_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int KRESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  atax_csr_if.slave   csr,
  output logic        ins_irq_irq,
  output logic        coe_start_export,
  input  logic        coe_finish_export,
  output logic        coe_kreset_export
);

  localparam int KW = $clog2(KRESET_CYCLES + 1);

  state_t            state, state_nx;
  logic [KW-1:0]     kcnt;
  logic              irq_en, done, tmo, aborted;
  logic [DATA_W-1:0] timeout, cycles, rd_mux;
  logic              hit, launch, fin_evt, tmo_evt, abt_evt, cnt_en;
  logic              ctrl_wr, status_wr, timeout_wr;

  assign ctrl_wr    = csr.avs_csr_write && (csr.avs_csr_address == ADDR_CTRL);
  assign status_wr  = csr.avs_csr_write && (csr.avs_csr_address == ADDR_STATUS);
  assign timeout_wr = csr.avs_csr_write && (csr.avs_csr_address == ADDR_TIMEOUT);

  atax_run_counter #(.W(DATA_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (launch),
    .en    (cnt_en),
    .limit (timeout),
    .count (cycles),
    .hit   (hit)
  );

  // Finish has priority over timeout and abort; the counter only advances on
  // cycles where the run continues, so it freezes at the terminating value.
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    fin_evt  = 1'b0;
    tmo_evt  = 1'b0;
    abt_evt  = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_wr && csr.avs_csr_writedata[CTRL_START]) begin
          state_nx = S_RUN;
          launch   = 1'b1;
        end
      end
      S_RUN: begin
        if (coe_finish_export) begin
          state_nx = S_IDLE;
          fin_evt  = 1'b1;
        end else begin
          tmo_evt = hit;
          abt_evt = ctrl_wr && csr.avs_csr_writedata[CTRL_ABORT];
          if (tmo_evt || abt_evt) state_nx = S_KRST;
          else                    cnt_en   = 1'b1;
        end
      end
      S_KRST: begin
        if (kcnt == '0) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      kcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state != S_KRST && state_nx == S_KRST) kcnt <= KW'(KRESET_CYCLES - 1);
      else if (state == S_KRST && kcnt != '0)    kcnt <= kcnt - KW'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr.avs_csr_address)
      ADDR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
      ADDR_STATUS: begin
        rd_mux[ST_BUSY]    = (state != S_IDLE);
        rd_mux[ST_DONE]    = done;
        rd_mux[ST_TMO]     = tmo;
        rd_mux[ST_ABORTED] = aborted;
      end
      ADDR_CYCLES: rd_mux = cycles;
      default:     rd_mux = timeout;
    endcase
  end

  // Sticky flags: a set in the same cycle as its W1C clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en               <= 1'b0;
      timeout              <= '0;
      done                 <= 1'b0;
      tmo                  <= 1'b0;
      aborted              <= 1'b0;
      ins_irq_irq          <= 1'b0;
      coe_start_export     <= 1'b0;
      csr.avs_csr_readdata <= '0;
    end else begin
      if (ctrl_wr)    irq_en  <= csr.avs_csr_writedata[CTRL_IRQ_EN];
      if (timeout_wr) timeout <= csr.avs_csr_writedata;
      done    <= fin_evt | (done    & ~(status_wr & csr.avs_csr_writedata[ST_DONE]));
      tmo     <= tmo_evt | (tmo     & ~(status_wr & csr.avs_csr_writedata[ST_TMO]));
      aborted <= abt_evt | (aborted & ~(status_wr & csr.avs_csr_writedata[ST_ABORTED]));
      ins_irq_irq      <= irq_en & (done | tmo | aborted);
      coe_start_export <= launch;
      if (csr.avs_csr_read) csr.avs_csr_readdata <= rd_mux;
    end
  end

  assign coe_kreset_export = (state == S_KRST);

endmodule

// File: tb/tb_atax_csr_ctrl.sv
module tb_atax_csr_ctrl;
  localparam int KR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq, start, kreset;
  logic finish = 1'b0;

  int checks = 0;
  int failures = 0;

  atax_csr_if #(.DATA_W(32)) bus ();

  atax_csr_ctrl #(.DATA_W(32), .KRESET_CYCLES(KR)) dut (
    .clk               (clk),
    .reset             (reset),
    .csr               (bus),
    .ins_irq_irq       (irq),
    .coe_start_export  (start),
    .coe_finish_export (finish),
    .coe_kreset_export (kreset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 running, 2 kernel reset with m_kleft
  // kernel-reset cycles still to show.
  int          m_phase = 0;
  int          m_kleft = 0;
  logic [31:0] m_cycles = 0, m_timeout = 0, m_rdata = 0;
  bit          m_irq_en = 0, m_done = 0, m_tmo = 0, m_abt = 0;
  bit          m_irq = 0, m_start = 0, m_rvalid = 0;
  bit          go, fin, tmo_hit, abt;
  bit          wr_ctrl, wr_stat;
  logic [31:0] wd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_kleft = 0; m_cycles = 0; m_timeout = 0; m_rdata = 0;
      m_irq_en = 0; m_done = 0; m_tmo = 0; m_abt = 0;
      m_irq = 0; m_start = 0; m_rvalid = 0;
    end else begin
      wd      = bus.avs_csr_writedata;
      wr_ctrl = bus.avs_csr_write && bus.avs_csr_address == 2'd0;
      wr_stat = bus.avs_csr_write && bus.avs_csr_address == 2'd1;
      go      = (m_phase == 0) && wr_ctrl && wd[0];
      fin     = (m_phase == 1) && finish;
      tmo_hit = (m_phase == 1) && !finish && m_timeout != 0 && m_cycles == m_timeout;
      abt     = (m_phase == 1) && !finish && wr_ctrl && wd[2];

      m_rvalid = bus.avs_csr_read;
      if (bus.avs_csr_read) begin
        case (bus.avs_csr_address)
          2'd0:    m_rdata = m_irq_en ? 32'd2 : 32'd0;
          2'd1:    m_rdata = {28'd0, m_abt, m_tmo, m_done, m_phase != 0};
          2'd2:    m_rdata = m_cycles;
          default: m_rdata = m_timeout;
        endcase
      end
      m_irq   = m_irq_en && (m_done || m_tmo || m_abt);
      m_start = go;

      m_done = fin     || (m_done && !(wr_stat && wd[1]));
      m_tmo  = tmo_hit || (m_tmo  && !(wr_stat && wd[2]));
      m_abt  = abt     || (m_abt  && !(wr_stat && wd[3]));
      if (wr_ctrl) m_irq_en = wd[1];
      if (bus.avs_csr_write && bus.avs_csr_address == 2'd3) m_timeout = wd;

      if (go) m_cycles = 1;
      else if (m_phase == 1 && !fin && !tmo_hit && !abt && m_cycles != 32'hFFFF_FFFF)
        m_cycles = m_cycles + 1;

      if (m_phase == 2) begin
        m_kleft = m_kleft - 1;
        if (m_kleft == 0) m_phase = 0;
      end else if (go) m_phase = 1;
      else if (fin) m_phase = 0;
      else if (tmo_hit || abt) begin
        m_phase = 2;
        m_kleft = KR;
      end
    end
  end

  always @(negedge clk) begin
    check("start", {31'd0, start}, {31'd0, m_start});
    check("kreset", {31'd0, kreset}, {31'd0, m_phase == 2});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    if (m_rvalid) check("readdata", bus.avs_csr_readdata, m_rdata);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_csr_address = a; bus.avs_csr_writedata = d; bus.avs_csr_write = 1'b1;
    tick(1);
    bus.avs_csr_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.avs_csr_address = a; bus.avs_csr_read = 1'b1;
    tick(1);
    bus.avs_csr_read = 1'b0;
    v = bus.avs_csr_readdata;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick(1);
    finish = 1'b0;
  endtask

  logic [31:0] v;
  int r;

  initial begin
    bus.avs_csr_address = 0; bus.avs_csr_read = 0;
    bus.avs_csr_write = 0; bus.avs_csr_writedata = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    tick(1);

    // Reset values
    rd(2'd0, v); check("rst_ctrl", v, 32'd0);
    rd(2'd1, v); check("rst_status", v, 32'd0);
    rd(2'd2, v); check("rst_cycles", v, 32'd0);
    rd(2'd3, v); check("rst_timeout", v, 32'd0);

    // Normal run, finish in run cycle 101
    wr(2'd0, 32'd3);
    check("norm_start_hi", {31'd0, start}, 32'd1);
    tick(1); check("norm_start_lo", {31'd0, start}, 32'd0);
    tick(99);
    pulse_finish();
    rd(2'd1, v); check("norm_status", v, 32'd2);
    rd(2'd2, v); check("norm_cycles", v, 32'd101);
    check("norm_irq", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd2);
    tick(1); check("norm_irq_clr", {31'd0, irq}, 32'd0);

    // Timeout at 50
    wr(2'd3, 32'd50);
    wr(2'd0, 32'd1);
    tick(49); check("tmo_kr_pre", {31'd0, kreset}, 32'd0);
    tick(1);  check("tmo_kr_first", {31'd0, kreset}, 32'd1);
    tick(3);  check("tmo_kr_last", {31'd0, kreset}, 32'd1);
    tick(1);  check("tmo_kr_end", {31'd0, kreset}, 32'd0);
    rd(2'd1, v); check("tmo_status", v, 32'd4);
    rd(2'd2, v); check("tmo_cycles", v, 32'd50);
    wr(2'd1, 32'd4);
    wr(2'd3, 32'd0);

    // Abort at run cycle 10
    wr(2'd0, 32'd1);
    tick(9);
    wr(2'd0, 32'd4);
    check("abt_kr_first", {31'd0, kreset}, 32'd1);
    tick(3); check("abt_kr_last", {31'd0, kreset}, 32'd1);
    tick(1); check("abt_kr_end", {31'd0, kreset}, 32'd0);
    rd(2'd1, v); check("abt_status", v, 32'd8);
    rd(2'd2, v); check("abt_cycles", v, 32'd10);
    wr(2'd1, 32'd8);

    // Finish and timeout in the same cycle
    wr(2'd3, 32'd20);
    wr(2'd0, 32'd1);
    tick(19);
    pulse_finish();
    check("col_no_kr", {31'd0, kreset}, 32'd0);
    rd(2'd1, v); check("col_status", v, 32'd2);
    rd(2'd2, v); check("col_cycles", v, 32'd20);
    wr(2'd1, 32'd2);
    wr(2'd3, 32'd0);

    // START during RUN, then W1C DONE together with finish
    wr(2'd0, 32'd3);
    wr(2'd0, 32'd3);
    check("rerun_no_start", {31'd0, start}, 32'd0);
    tick(3);
    bus.avs_csr_address = 2'd1; bus.avs_csr_writedata = 32'd2; bus.avs_csr_write = 1'b1;
    finish = 1'b1;
    tick(1);
    bus.avs_csr_write = 1'b0; finish = 1'b0;
    rd(2'd1, v); check("w1c_set_wins", v, 32'd2);
    rd(2'd2, v); check("rerun_cycles", v, 32'd5);

    // Reset mid-run with DONE and IRQ still up
    wr(2'd0, 32'd3);
    tick(4);
    check("mid_irq_pre", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_start", {31'd0, start}, 32'd0);
    check("mid_kreset", {31'd0, kreset}, 32'd0);
    check("mid_irq", {31'd0, irq}, 32'd0);
    check("mid_rdata", bus.avs_csr_readdata, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    rd(2'd1, v); check("mid_status", v, 32'd0);
    rd(2'd2, v); check("mid_cycles", v, 32'd0);
    wr(2'd0, 32'd1);
    check("post_start", {31'd0, start}, 32'd1);
    tick(9);
    pulse_finish();
    rd(2'd2, v); check("post_cycles", v, 32'd10);
    rd(2'd1, v); check("post_status", v, 32'd2);
    wr(2'd1, 32'd2);

    // Read latency on every address, spurious finish while idle
    wr(2'd3, 32'hA5A5_0001);
    wr(2'd0, 32'd2);
    rd(2'd0, v); check("lat_ctrl", v, 32'd2);
    rd(2'd3, v); check("lat_timeout", v, 32'hA5A5_0001);
    rd(2'd2, v); check("lat_cycles", v, 32'd10);
    pulse_finish();
    tick(1);
    rd(2'd1, v); check("idle_finish_status", v, 32'd0);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      finish = ($urandom_range(0, 39) == 0);
      if (r < 8) begin
        bus.avs_csr_address = 2'd0; bus.avs_csr_write = 1'b1;
        bus.avs_csr_writedata = {29'd0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
      end else if (r < 14) begin
        bus.avs_csr_address = 2'd1; bus.avs_csr_write = 1'b1;
        bus.avs_csr_writedata = $urandom & 32'hF;
      end else if (r < 17) begin
        bus.avs_csr_address = 2'd3; bus.avs_csr_write = 1'b1;
        bus.avs_csr_writedata = $urandom_range(0, 40);
      end else if (r < 45) begin
        bus.avs_csr_address = 2'($urandom_range(0, 3)); bus.avs_csr_read = 1'b1;
      end
      tick(1);
      bus.avs_csr_write = 1'b0; bus.avs_csr_read = 1'b0; finish = 1'b0;
    end
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
